fifo_ctrl: RTL and testbench

FIFO_CTRL -- requirements
Module: fifo_ctrl

---
 rtl/fifo_ctrl_pkg.sv | 16 +
 rtl/fifo_ctrl_ns.sv | 25 ++
 rtl/fifo_ctrl.sv | 122 ++++++++++++
 tb/tb_fifo_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the FIFO controller: default geometry and state codes.
package fifo_ctrl_pkg;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned AW     = 3;
  localparam int unsigned DATA_W = 32;

  // Operation performed in the current cycle; codes are fixed for legacy software.
  localparam logic [2:0] ST_INIT   = 3'b000;
  localparam logic [2:0] ST_WRITE  = 3'b001;
  localparam logic [2:0] ST_READ   = 3'b010;
  localparam logic [2:0] ST_WR_ERR = 3'b011;
  localparam logic [2:0] ST_NO_OP  = 3'b100;
  localparam logic [2:0] ST_RD_ERR = 3'b101;

endpackage

// File: rtl/fifo_ctrl_ns.sv
// Next-operation selection from the requests and the post-update entry count.
module fifo_ns #(
  parameter int unsigned DEPTH = fifo_ctrl_pkg::DEPTH,
  parameter int unsigned AW    = fifo_ctrl_pkg::AW
) (
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic [AW:0]   cnt_nx,
  output logic [2:0]    state_nx
);
  import fifo_ctrl_pkg::*;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  // Single request picks write/read or its error; none or both is a no-op.
  always_comb begin
    state_nx = ST_NO_OP;
    if (wr_en && !rd_en) begin
      state_nx = (cnt_nx >= DEPTH_C) ? ST_WR_ERR : ST_WRITE;
    end else if (rd_en && !wr_en) begin
      state_nx = (cnt_nx == '0) ? ST_RD_ERR : ST_READ;
    end
  end

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO controller: one operation per cycle, named by the state register,
// with pointers, count and data register committing at the end of that cycle.
module fifo_ctrl #(
  parameter int unsigned DEPTH  = fifo_ctrl_pkg::DEPTH,
  parameter int unsigned DATA_W = fifo_ctrl_pkg::DATA_W,
  parameter int unsigned AW     = fifo_ctrl_pkg::AW
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [2:0]        state,
  output logic [AW-1:0]     head,
  output logic [AW-1:0]     tail,
  output logic [AW:0]       data_count,
  output logic              we,
  output logic              re,
  output logic              full,
  output logic              empty,
  output logic              wr_ack,
  output logic              wr_err,
  output logic              rd_ack,
  output logic              rd_err
);
  import fifo_ctrl_pkg::*;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [2:0]        state_q, state_d;
  logic [AW-1:0]     head_q, head_d;
  logic [AW-1:0]     tail_q, tail_d;
  logic [AW:0]       count_q, count_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              do_wr, do_rd;

  // Current-cycle operation; unused codes fall through as no-op.
  always_comb begin
    do_wr = (state_q == ST_WRITE);
    do_rd = (state_q == ST_READ);
  end

  // Pointer/count/data updates that commit at the end of this cycle.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    dout_d  = dout_q;
    if (do_wr) begin
      tail_d  = tail_q + AW'(1);
      count_d = count_q + (AW+1)'(1);
    end
    if (do_rd) begin
      head_d  = head_q + AW'(1);
      count_d = count_q - (AW+1)'(1);
      dout_d  = mem[head_q];
    end
  end

  // Next state is chosen from the count as it will be after this cycle.
  fifo_ns #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ns (
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .cnt_nx   (count_d),
    .state_nx (state_d)
  );

  // Write data is staged only when a write is about to be performed.
  always_comb begin
    din_d = (state_d == ST_WRITE) ? din : din_q;
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_INIT;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      din_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      din_q   <= din_d;
      dout_q  <= dout_d;
    end
  end

  // Storage is not reset; reset during a write cancels the store.
  always_ff @(posedge clk) begin
    if (reset_n && do_wr) begin
      mem[tail_q] <= din_q;
    end
  end

  // Status outputs are combinational on the registered state and count.
  always_comb begin
    dout       = dout_q;
    state      = state_q;
    head       = head_q;
    tail       = tail_q;
    data_count = count_q;
    we         = do_wr;
    re         = do_rd;
    full       = (count_q == DEPTH_C);
    empty      = (count_q == '0);
    wr_ack     = (state_q == ST_WRITE);
    wr_err     = (state_q == ST_WR_ERR);
    rd_ack     = (state_q == ST_READ);
    rd_err     = (state_q == ST_RD_ERR);
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Scoreboard bench for fifo_ctrl against a queue-based reference model.
module tb_fifo_ctrl;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 32;
  localparam int AW     = 3;

  localparam int K_WACK = 1;
  localparam int K_WERR = 2;
  localparam int K_RACK = 3;
  localparam int K_RERR = 4;

  localparam int P_NONE = 0;
  localparam int P_WR   = 1;
  localparam int P_RD   = 2;

  typedef struct {
    int          kind;
    logic [31:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              wr_en, rd_en;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic [2:0]        state;
  logic [AW-1:0]     head, tail;
  logic [AW:0]       data_count;
  logic              we, re, full, empty, wr_ack, wr_err, rd_ack, rd_err;

  int tests = 0;
  int fails = 0;

  // reference model: stored words, pending operation, pointers
  logic [31:0] mq[$];
  int          pend = P_NONE;
  logic [31:0] pend_data;
  int          m_head = 0;
  int          m_tail = 0;

  exp_t        sb[$];
  logic        dout_chk = 1'b0;
  logic [31:0] dout_exp;

  fifo_ctrl #(.DEPTH(DEPTH), .DATA_W(DATA_W), .AW(AW)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .rd_en(rd_en), .din(din),
    .dout(dout), .state(state), .head(head), .tail(tail), .data_count(data_count),
    .we(we), .re(re), .full(full), .empty(empty), .wr_ack(wr_ack), .wr_err(wr_err),
    .rd_ack(rd_ack), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference behaviour at a clock edge: finish the operation in flight,
  // then decide the next one from the request and the resulting occupancy.
  task automatic model_edge(input logic w, input logic r, input logic [31:0] d);
    logic [31:0] tmp;
    if (!reset_n) begin
      mq.delete();
      pend   = P_NONE;
      m_head = 0;
      m_tail = 0;
      return;
    end
    if (pend == P_WR) begin
      mq.push_back(pend_data);
      m_tail = (m_tail + 1) % DEPTH;
    end else if (pend == P_RD) begin
      tmp    = mq.pop_front();
      m_head = (m_head + 1) % DEPTH;
    end
    pend = P_NONE;
    if (w && !r) begin
      if (mq.size() == DEPTH) sb.push_back('{K_WERR, 32'h0});
      else begin
        pend      = P_WR;
        pend_data = d;
        sb.push_back('{K_WACK, d});
      end
    end else if (r && !w) begin
      if (mq.size() == 0) sb.push_back('{K_RERR, 32'h0});
      else begin
        pend = P_RD;
        sb.push_back('{K_RACK, mq[0]});
      end
    end
  endtask

  task automatic check_model();
    check("data_count", data_count, mq.size());
    check("head", head, m_head);
    check("tail", tail, m_tail);
    check("full", full, mq.size() == DEPTH);
    check("empty", empty, mq.size() == 0);
  endtask

  task automatic cycle(input logic w, input logic r, input logic [31:0] d);
    wr_en = w;
    rd_en = r;
    din   = d;
    @(posedge clk);
    model_edge(w, r, d);
    @(negedge clk);
    check_model();
  endtask

  // Monitor: every response flag pops one expectation; read data follows a cycle later.
  always @(negedge clk) begin
    int   nf;
    int   kind;
    exp_t e;
    if (dout_chk) begin
      check("dout", dout, dout_exp);
      dout_chk = 1'b0;
    end
    nf = int'(wr_ack === 1'b1) + int'(wr_err === 1'b1) + int'(rd_ack === 1'b1) + int'(rd_err === 1'b1);
    if (nf > 1) begin
      check("flags_onehot", nf, 1);
    end else if (nf == 1) begin
      kind = (wr_ack === 1'b1) ? K_WACK : (wr_err === 1'b1) ? K_WERR :
             (rd_ack === 1'b1) ? K_RACK : K_RERR;
      if (sb.size() == 0) begin
        check("unexpected_response", kind, 0);
      end else begin
        e = sb.pop_front();
        check("response_kind", kind, e.kind);
        if (kind == K_WACK) check("we_strobe", we, 1'b1);
        if (kind == K_RACK) begin
          check("re_strobe", re, 1'b1);
          dout_chk = 1'b1;
          dout_exp = e.data;
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    din     = '0;

    // reset
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    reset_n = 1'b1;
    check("rst_state", state, 3'b000);
    check("rst_dout", dout, 0);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_flags", {wr_ack, wr_err, rd_ack, rd_err}, 4'b0000);

    // fill with 0x11..0x88
    for (int i = 1; i <= 8; i++) cycle(1, 0, 32'h11 * i);
    cycle(0, 0, 0);
    check("fill_count", data_count, 8);
    check("fill_full", full, 1'b1);
    check("fill_tail", tail, 0);

    // write while full
    cycle(1, 0, 32'h99);
    check("werr_state", state, 3'b011);
    check("werr_flag", wr_err, 1'b1);
    check("werr_count", data_count, 8);
    cycle(0, 0, 0);
    check("werr_one_cycle", wr_err, 1'b0);

    // drain, then read from empty
    for (int i = 0; i < 8; i++) cycle(0, 1, 0);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    check("drain_head", head, 0);
    check("drain_empty", empty, 1'b1);
    check("drain_last_dout", dout, 32'h88);
    cycle(0, 1, 0);
    check("rerr_flag", rd_err, 1'b1);
    cycle(0, 0, 0);

    // simultaneous request is a no-op
    for (int i = 0; i < 3; i++) cycle(1, 0, 32'hA0 + i);
    cycle(0, 0, 0);
    cycle(1, 1, 32'hDEAD);
    check("noop_state", state, 3'b100);
    check("noop_flags", {wr_ack, wr_err, rd_ack, rd_err}, 4'b0000);
    check("noop_count", data_count, 3);
    cycle(0, 0, 0);

    // alternating write/read from empty
    reset_n = 1'b0;
    cycle(0, 0, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle(i % 2 == 0, i % 2 == 1, $urandom);
      check("alt_count_le1", data_count <= 1, 1'b1);
      check("alt_no_err", wr_err | rd_err, 1'b0);
    end
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    check("alt_tail_wrapped", tail, 10 % DEPTH);

    // reset during a write with five entries stored
    for (int i = 0; i < 5; i++) cycle(1, 0, $urandom);
    cycle(0, 0, 0);
    cycle(1, 0, 32'h5555);
    check("abort_pre_state", state, 3'b001);
    check("abort_pre_count", data_count, 5);
    reset_n = 1'b0;
    cycle(0, 0, 0);
    reset_n = 1'b1;
    check("abort_state", state, 3'b000);
    check("abort_count", data_count, 0);
    check("abort_we", we, 1'b0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45, $urandom);
    end
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    check("sb_drained", sb.size(), 0);
    check("dout_check_done", dout_chk, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
